// File: rtl/spmv_mem_arbiter.sv
// spmv_mem_arbiter: arbitrates result stores, x-vector loads and matrix-stream
// loads onto a single memory request port through a 4-entry request queue.
module spmv_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned IDLE_CYCLES  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_ld,
  input  logic [47:0] cfg_st_base,
  input  logic [47:0] cfg_st_end,
  input  logic        st_valid,
  input  logic [63:0] st_data,
  output logic        st_ready,
  input  logic        xl_valid,
  input  logic [47:0] xl_addr,
  output logic        xl_ready,
  input  logic        ml_valid,
  input  logic [47:0] ml_addr,
  input  logic [1:0]  ml_tag,
  output logic        ml_ready,
  output logic        req_mem_ld,
  output logic        req_mem_st,
  output logic [47:0] req_mem_addr,
  output logic [63:0] req_mem_d_or_tag,
  input  logic        req_mem_stall,
  output logic [15:0] st_drop_cnt,
  output logic        idle
);

  localparam int unsigned AW  = 48;
  localparam int unsigned DW  = 64;
  localparam int unsigned QD  = 4;
  localparam int unsigned QAW = 2;
  localparam int unsigned CW  = 3;
  localparam int unsigned SW  = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int unsigned IW  = (IDLE_CYCLES  > 0) ? $clog2(IDLE_CYCLES + 1)  : 1;
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [IW-1:0] IDLE_MAX   = IW'(IDLE_CYCLES);
  localparam logic [15:0]   DROP_MAX   = 16'hFFFF;

  // request queue storage and control
  logic            r_q_st   [QD];
  logic [AW-1:0]   r_q_addr [QD];
  logic [DW-1:0]   r_q_data [QD];
  logic [QAW-1:0]  r_head;
  logic [QAW-1:0]  r_tail;
  logic [CW-1:0]   r_count;
  logic            r_stall;

  // store window, starvation and idle tracking
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_st_end;
  logic [15:0]     r_drop;
  logic [SW-1:0]   r_starve;
  logic [IW-1:0]   r_idle_cnt;

  // registered memory request port
  logic            r_mem_ld;
  logic            r_mem_st;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_data;

  logic            w_room;
  logic            w_st_req;
  logic            w_starved;
  logic            w_gnt_st;
  logic            w_gnt_xl;
  logic            w_gnt_ml;
  logic            w_st_hit_end;
  logic            w_push;
  logic            w_pop;
  logic            w_any_valid;
  logic            w_quiet;
  logic [AW-1:0]   w_push_addr;
  logic [DW-1:0]   w_push_data;

  // Grant only while out of reset and with headroom for one more in-flight push
  // (the stall is registered, so a full 4th slot must stay free).
  assign w_room       = rst_n && (r_count < CW'(QD - 1));
  assign w_st_req     = st_valid && !cfg_ld;
  assign w_starved    = (r_starve == STARVE_MAX);
  assign w_st_hit_end = (r_wr_ptr == r_st_end);
  assign w_pop        = (r_count != '0) && !r_stall;
  assign w_any_valid  = st_valid || xl_valid || ml_valid;
  assign w_quiet      = (r_count == '0) && !r_mem_ld && !r_mem_st && !w_any_valid;

  // Priority select: st > xl > ml, with ml promoted to the top once starved.
  always_comb begin
    w_gnt_st = 1'b0;
    w_gnt_xl = 1'b0;
    w_gnt_ml = 1'b0;
    if (w_room) begin
      if (w_starved && ml_valid) begin
        w_gnt_ml = 1'b1;
      end else if (w_st_req) begin
        w_gnt_st = 1'b1;
      end else if (xl_valid) begin
        w_gnt_xl = 1'b1;
      end else if (ml_valid) begin
        w_gnt_ml = 1'b1;
      end
    end
  end

  assign st_ready = w_gnt_st;
  assign xl_ready = w_gnt_xl;
  assign ml_ready = w_gnt_ml;

  // A store at the window end still handshakes but is discarded.
  assign w_push = w_gnt_xl || w_gnt_ml || (w_gnt_st && !w_st_hit_end);

  // Encode the granted request into a queue entry.
  always_comb begin
    w_push_addr = ml_addr;
    w_push_data = {61'b0, ml_tag, 1'b0};
    if (w_gnt_st) begin
      w_push_addr = r_wr_ptr;
      w_push_data = st_data;
    end else if (w_gnt_xl) begin
      w_push_addr = xl_addr;
      w_push_data = 64'h1;
    end
  end

  // Queue payload write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_st[r_tail]   <= w_gnt_st;
      r_q_addr[r_tail] <= w_push_addr;
      r_q_data[r_tail] <= w_push_data;
    end
  end

  // Queue pointers, occupancy and registered stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_stall <= 1'b0;
    end else begin
      r_stall <= req_mem_stall;
      if (w_push) r_tail <= r_tail + QAW'(1);
      if (w_pop)  r_head <= r_head + QAW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Store window: load on cfg_ld, advance per accepted store, count drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_st_end <= '0;
      r_drop   <= '0;
    end else if (cfg_ld) begin
      r_wr_ptr <= cfg_st_base;
      r_st_end <= cfg_st_end;
      r_drop   <= '0;
    end else if (w_gnt_st) begin
      if (w_st_hit_end) begin
        if (r_drop != DROP_MAX) r_drop <= r_drop + 16'd1;
      end else begin
        r_wr_ptr <= r_wr_ptr + AW'(8);
      end
    end
  end

  // Starvation counter for the matrix-stream requester.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (ml_valid && !w_gnt_ml) begin
      if (r_starve != STARVE_MAX) r_starve <= r_starve + SW'(1);
    end else begin
      r_starve <= '0;
    end
  end

  // Consecutive quiet-cycle counter behind the idle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (w_quiet) begin
      if (r_idle_cnt != IDLE_MAX) r_idle_cnt <= r_idle_cnt + IW'(1);
    end else begin
      r_idle_cnt <= '0;
    end
  end

  // Drive the memory port from the popped entry; strobes last one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_ld   <= 1'b0;
      r_mem_st   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else if (w_pop) begin
      r_mem_ld   <= !r_q_st[r_head];
      r_mem_st   <= r_q_st[r_head];
      r_mem_addr <= r_q_addr[r_head];
      r_mem_data <= r_q_data[r_head];
    end else begin
      r_mem_ld   <= 1'b0;
      r_mem_st   <= 1'b0;
    end
  end

  assign req_mem_ld       = r_mem_ld;
  assign req_mem_st       = r_mem_st;
  assign req_mem_addr     = r_mem_addr;
  assign req_mem_d_or_tag = r_mem_data;
  assign st_drop_cnt      = r_drop;
  assign idle             = (r_idle_cnt == IDLE_MAX) && !w_any_valid;

endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Directed self-checking bench for spmv_mem_arbiter.
module tb_spmv_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        cfg_ld;
  logic [47:0] cfg_st_base;
  logic [47:0] cfg_st_end;
  logic        st_valid;
  logic [63:0] st_data;
  logic        st_ready;
  logic        xl_valid;
  logic [47:0] xl_addr;
  logic        xl_ready;
  logic        ml_valid;
  logic [47:0] ml_addr;
  logic [1:0]  ml_tag;
  logic        ml_ready;
  logic        req_mem_ld;
  logic        req_mem_st;
  logic [47:0] req_mem_addr;
  logic [63:0] req_mem_d_or_tag;
  logic        req_mem_stall;
  logic [15:0] st_drop_cnt;
  logic        idle;

  int n_vec = 0;
  int n_err = 0;

  spmv_mem_arbiter dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_ld           (cfg_ld),
    .cfg_st_base      (cfg_st_base),
    .cfg_st_end       (cfg_st_end),
    .st_valid         (st_valid),
    .st_data          (st_data),
    .st_ready         (st_ready),
    .xl_valid         (xl_valid),
    .xl_addr          (xl_addr),
    .xl_ready         (xl_ready),
    .ml_valid         (ml_valid),
    .ml_addr          (ml_addr),
    .ml_tag           (ml_tag),
    .ml_ready         (ml_ready),
    .req_mem_ld       (req_mem_ld),
    .req_mem_st       (req_mem_st),
    .req_mem_addr     (req_mem_addr),
    .req_mem_d_or_tag (req_mem_d_or_tag),
    .req_mem_stall    (req_mem_stall),
    .st_drop_cnt      (st_drop_cnt),
    .idle             (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // compare one observed value against its expected value
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          hs;
  int          j;
  logic        exp_rdy;

  initial begin
    rst_n = 1'b1;
    cfg_ld = 1'b0; cfg_st_base = '0; cfg_st_end = '0;
    st_valid = 1'b1; st_data = '0;
    xl_valid = 1'b1; xl_addr = '0;
    ml_valid = 1'b1; ml_addr = '0; ml_tag = '0;
    req_mem_stall = 1'b0;
    #2 rst_n = 1'b0;

    // reset state, readys held low even with all valids up
    tick(); tick();
    chk("rst_st_ready", 64'(st_ready), 64'd0);
    chk("rst_xl_ready", 64'(xl_ready), 64'd0);
    chk("rst_ml_ready", 64'(ml_ready), 64'd0);
    chk("rst_ld", 64'(req_mem_ld), 64'd0);
    chk("rst_st", 64'(req_mem_st), 64'd0);
    chk("rst_addr", 64'(req_mem_addr), 64'd0);
    chk("rst_data", req_mem_d_or_tag, 64'd0);
    chk("rst_drop", 64'(st_drop_cnt), 64'd0);
    chk("rst_idle", 64'(idle), 64'd0);

    // idle after 32 quiet cycles, dropped combinationally by a valid
    st_valid = 1'b0; xl_valid = 1'b0; ml_valid = 1'b0;
    rst_n = 1'b1;
    repeat (31) tick();
    chk("idle_31", 64'(idle), 64'd0);
    tick();
    chk("idle_32", 64'(idle), 64'd1);
    repeat (7) tick();
    xl_valid = 1'b1; xl_addr = 48'h3000;
    #1;
    chk("idle_xl_drop", 64'(idle), 64'd0);
    chk("idle_xl_ready", 64'(xl_ready), 64'd1);
    tick();
    xl_valid = 1'b0;
    chk("xl_lat1_ld", 64'(req_mem_ld), 64'd0);
    tick();
    chk("xl_out_ld", 64'(req_mem_ld), 64'd1);
    chk("xl_out_addr", 64'(req_mem_addr), 64'h3000);
    chk("xl_out_data", req_mem_d_or_tag, 64'h1);
    tick();
    chk("xl_done_ld", 64'(req_mem_ld), 64'd0);
    chk("xl_hold_addr", 64'(req_mem_addr), 64'h3000);

    // single ml transfer: output two cycles later with tag encoding
    ml_valid = 1'b1; ml_addr = 48'h2000; ml_tag = 2'b10;
    #1;
    chk("ml_ready", 64'(ml_ready), 64'd1);
    tick();
    ml_valid = 1'b0;
    chk("ml_lat1_ld", 64'(req_mem_ld), 64'd0);
    tick();
    chk("ml_out_ld", 64'(req_mem_ld), 64'd1);
    chk("ml_out_addr", 64'(req_mem_addr), 64'h2000);
    chk("ml_out_tag", req_mem_d_or_tag, 64'h4);

    // store before any window load is dropped
    st_valid = 1'b1; st_data = 64'hDEAD;
    #1;
    chk("pre_st_ready", 64'(st_ready), 64'd1);
    tick();
    st_valid = 1'b0;
    chk("pre_drop", 64'(st_drop_cnt), 64'd1);
    tick();
    chk("pre_no_st", 64'(req_mem_st), 64'd0);

    // store window 0x1000..0x1010: two stores land, third drops
    cfg_ld = 1'b1; cfg_st_base = 48'h1000; cfg_st_end = 48'h1010;
    st_valid = 1'b1; st_data = 64'hAAAA_0001;
    #1;
    chk("cfg_st_ready", 64'(st_ready), 64'd0);
    tick();
    cfg_ld = 1'b0;
    chk("cfg_drop_clr", 64'(st_drop_cnt), 64'd0);
    #1;
    chk("win_st_ready", 64'(st_ready), 64'd1);
    tick();
    st_data = 64'hBBBB_0002;
    tick();
    chk("win_a_st", 64'(req_mem_st), 64'd1);
    chk("win_a_addr", 64'(req_mem_addr), 64'h1000);
    chk("win_a_data", req_mem_d_or_tag, 64'hAAAA_0001);
    st_data = 64'hCCCC_0003;
    tick();
    chk("win_b_st", 64'(req_mem_st), 64'd1);
    chk("win_b_addr", 64'(req_mem_addr), 64'h1008);
    chk("win_b_data", req_mem_d_or_tag, 64'hBBBB_0002);
    chk("win_drop", 64'(st_drop_cnt), 64'd1);
    st_valid = 1'b0;
    tick();
    chk("win_c_none", 64'(req_mem_st), 64'd0);
    chk("win_drop_hold", 64'(st_drop_cnt), 64'd1);

    // all three requesters continuously valid: ml wins on its 9th cycle
    cfg_ld = 1'b1; cfg_st_base = 48'h4000; cfg_st_end = 48'h5000;
    tick();
    cfg_ld = 1'b0;
    st_valid = 1'b1; xl_valid = 1'b1; xl_addr = 48'hA000;
    ml_valid = 1'b1; ml_addr = 48'h6000; ml_tag = 2'b01;
    for (int k = 1; k <= 11; k++) begin
      if (k == 11) begin
        st_valid = 1'b0; xl_valid = 1'b0; ml_valid = 1'b0;
      end else begin
        st_data = 64'hD000 + 64'(k);
        #1;
        chk("starve_gnt", 64'({st_ready, xl_ready, ml_ready}), (k == 9) ? 64'b001 : 64'b100);
      end
      tick();
      if (k >= 2) begin
        j = k - 1;
        if (j == 9) begin
          chk("starve_ml_ld", 64'(req_mem_ld), 64'd1);
          chk("starve_ml_addr", 64'(req_mem_addr), 64'h6000);
          chk("starve_ml_tag", req_mem_d_or_tag, 64'h2);
        end else begin
          chk("starve_st", 64'(req_mem_st), 64'd1);
          chk("starve_st_addr", 64'(req_mem_addr), 64'h4000 + 64'(8 * ((j < 9) ? j - 1 : j - 2)));
          chk("starve_st_data", req_mem_d_or_tag, 64'hD000 + 64'(j));
        end
      end
    end
    tick();
    chk("starve_drain", 64'({req_mem_ld, req_mem_st}), 64'd0);

    // stall for 10 cycles with xl pending: 3 queued, then FIFO drain
    hs = 0;
    for (int c = 1; c <= 16; c++) begin
      exp_rdy = (c <= 3) || (c == 13);
      xl_valid = (c <= 13);
      xl_addr = 48'h7000 + 48'(hs * 64);
      req_mem_stall = (c <= 10);
      #1;
      if (c <= 13) chk("stall_xl_ready", 64'(xl_ready), 64'(exp_rdy));
      if (exp_rdy) hs++;
      tick();
      if (c >= 12 && c <= 15) begin
        chk("stall_out_ld", 64'(req_mem_ld), 64'd1);
        chk("stall_out_addr", 64'(req_mem_addr), 64'h7000 + 64'(64 * (c - 12)));
      end else begin
        chk("stall_out_quiet", 64'(req_mem_ld), 64'd0);
      end
    end
    xl_valid = 1'b0;

    // reset with two requests still queued: nothing replays afterwards
    req_mem_stall = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      xl_valid = 1'b1;
      xl_addr = 48'h8000 + 48'(64 * (c - 1));
      #1;
      chk("rq_xl_ready", 64'(xl_ready), 64'd1);
      tick();
    end
    xl_valid = 1'b0; req_mem_stall = 1'b0;
    tick();
    tick();
    chk("rq_first_ld", 64'(req_mem_ld), 64'd1);
    chk("rq_first_addr", 64'(req_mem_addr), 64'h8000);
    xl_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rq_async_ld", 64'(req_mem_ld), 64'd0);
    chk("rq_async_addr", 64'(req_mem_addr), 64'd0);
    chk("rq_rst_ready", 64'(xl_ready), 64'd0);
    tick();
    tick();
    xl_valid = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("rq_no_replay", 64'({req_mem_ld, req_mem_st}), 64'd0);
    end

    // window wrapping past 2^48, with xl granted during cfg_ld
    cfg_ld = 1'b1; cfg_st_base = 48'hFFFF_FFFF_FFF8; cfg_st_end = 48'h8;
    st_valid = 1'b1; st_data = 64'hE1;
    xl_valid = 1'b1; xl_addr = 48'h9000;
    #1;
    chk("wr_cfg_st_ready", 64'(st_ready), 64'd0);
    chk("wr_cfg_xl_ready", 64'(xl_ready), 64'd1);
    tick();
    cfg_ld = 1'b0; xl_valid = 1'b0;
    #1;
    chk("wr_st_ready", 64'(st_ready), 64'd1);
    tick();
    chk("wr_xl_ld", 64'(req_mem_ld), 64'd1);
    chk("wr_xl_addr", 64'(req_mem_addr), 64'h9000);
    st_data = 64'hE2;
    tick();
    chk("wr_s1_st", 64'(req_mem_st), 64'd1);
    chk("wr_s1_addr", 64'(req_mem_addr), 64'hFFFF_FFFF_FFF8);
    chk("wr_s1_data", req_mem_d_or_tag, 64'hE1);
    st_data = 64'hE3;
    tick();
    chk("wr_s2_st", 64'(req_mem_st), 64'd1);
    chk("wr_s2_addr", 64'(req_mem_addr), 64'h0);
    chk("wr_s2_data", req_mem_d_or_tag, 64'hE2);
    chk("wr_drop", 64'(st_drop_cnt), 64'd1);
    st_valid = 1'b0;
    tick();
    chk("wr_s3_none", 64'(req_mem_st), 64'd0);
    chk("wr_drop_hold", 64'(st_drop_cnt), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
